// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator result path: the result transmit
// sequencer state encoding and the bit positions within the result request bus.
package acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_FIN
    } tx_seq_state_t;

    localparam int RES_REQ_BIT = 1;
    localparam int RES_VEC_BIT = 0;

endpackage

// File: rtl/result_tx_sequencer.sv
// Streams a vector result (from the result RAM) or a scalar result one byte at a
// time into the UART output interface, handshaking each byte on send/tx_done.
//
// Handshake: send is a one-cycle request to the output interface to transmit
// tx_output; the byte is considered gone only when tx_done pulses while this
// block is in WAIT. tx_done seen in any other state is ignored.
module result_tx_sequencer
    import acc_pkg::*;
#(
    parameter int NBytes       = 1024,
    parameter int SCALAR_BYTES = 4,
    localparam int IdxW        = $clog2(NBytes)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                result,
    input  logic [8*SCALAR_BYTES-1:0] scalar,
    output logic [IdxW-1:0]           rd_addr,
    input  logic [7:0]                rd_data,
    input  logic                      tx_done,
    output logic                      send,
    output logic [7:0]                tx_output,
    output logic                      busy,
    output logic                      done,
    output tx_seq_state_t             dbg_state_o
);

    tx_seq_state_t             state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic                      vec_q, vec_d;
    logic [8*SCALAR_BYTES-1:0] scalar_q, scalar_d;
    logic [7:0]                tx_q, tx_d;
    logic                      req_q;

    logic                      start;
    logic [IdxW-1:0]           last_idx;
    logic [7:0]                scalar_byte;

    // Only a fresh rising edge starts a transfer; a level held across FIN is inert.
    assign start    = (state_q == ST_IDLE) && result[RES_REQ_BIT] && !req_q;
    assign last_idx = vec_q ? IdxW'(NBytes - 1) : IdxW'(SCALAR_BYTES - 1);

    always_comb begin
        scalar_byte = 8'h00;
        for (int k = 0; k < SCALAR_BYTES; k++) begin
            if (idx_q == IdxW'(k)) begin
                scalar_byte = scalar_q[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            vec_q    <= 1'b0;
            scalar_q <= '0;
            tx_q     <= 8'h00;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            scalar_q <= scalar_d;
            tx_q     <= tx_d;
            req_q    <= result[RES_REQ_BIT];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vec_d    = vec_q;
        scalar_d = scalar_q;
        tx_d     = tx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d    = result[RES_VEC_BIT];
                    scalar_d = scalar;
                    idx_d    = '0;
                    state_d  = result[RES_VEC_BIT] ? ST_FETCH : ST_LOAD;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                tx_d    = vec_q ? rd_data : scalar_byte;
                state_d = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    if (idx_q == last_idx) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = vec_q ? ST_FETCH : ST_LOAD;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_addr     = idx_q;
    assign send        = (state_q == ST_SEND);
    assign tx_output   = tx_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed bench for result_tx_sequencer with an 8-byte result RAM and a UART
// model that answers each send with tx_done five cycles later.
module tb_result_tx_sequencer;
    import acc_pkg::*;

    localparam int NB = 8;
    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    result;
    logic [31:0]   scalar;
    logic [2:0]    rd_addr;
    logic [7:0]    rd_data;
    logic          tx_done;
    logic          send;
    logic [7:0]    tx_output;
    logic          busy;
    logic          done;
    tx_seq_state_t dbg_state;

    logic          uart_done;
    logic          spur_done;
    logic [7:0]    ram [NB];

    logic [7:0]    got_q [$];
    logic [7:0]    exp_q [$];
    logic [2:0]    addr_q [$];
    int            send_cyc_q [$];
    int            done_cnt;
    int            cyc;
    int            pass_cnt;
    int            total_cnt;

    assign tx_done = uart_done | spur_done;

    result_tx_sequencer #(.NBytes(NB), .SCALAR_BYTES(SB)) dut (
        .clk        (clk),
        .reset      (reset),
        .result     (result),
        .scalar     (scalar),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx_done    (tx_done),
        .send       (send),
        .tx_output  (tx_output),
        .busy       (busy),
        .done       (done),
        .dbg_state_o(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // result RAM: synchronous read, one-cycle latency
    initial begin
        for (int i = 0; i < NB; i++) ram[i] = 8'hA0 + 8'(i);
    end
    always @(posedge clk) rd_data <= ram[rd_addr];

    // UART model: tx_done is sampled by the DUT at the fifth edge after send
    initial begin
        uart_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (send) begin
                repeat (4) @(posedge clk);
                #1 uart_done = 1'b1;
                @(posedge clk);
                #1 uart_done = 1'b0;
            end
        end
    end

    // monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (send) begin
            got_q.push_back(tx_output);
            send_cyc_q.push_back(cyc);
        end
        if (dbg_state == ST_FETCH) addr_q.push_back(rd_addr);
        if (done) done_cnt = done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        addr_q.delete();
        send_cyc_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_transfer(input int max_cyc, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (done_cnt == 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) timed_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        result = 2'b00;
        scalar = 32'h0;
        spur_done = 1'b0;
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (send !== 1'b0) $display("FAIL reset_send: got %b want 0", send); else pass_cnt++;
        total_cnt++; if (tx_output !== 8'h00) $display("FAIL reset_tx_output: got %h want 00", tx_output); else pass_cnt++;
        total_cnt++; if (rd_addr !== 3'd0) $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_vector();
        bit to;
        int t0;
        clear_mon();
        for (int i = 0; i < NB; i++) exp_q.push_back(8'hA0 + 8'(i));
        @(posedge clk);
        #1 result = 2'b11;
        t0 = cyc;
        @(posedge clk);
        #1 result = 2'b00;
        wait_transfer(400, to);
        total_cnt++; if (to) $display("FAIL vec_timeout: no done within 400 cycles"); else pass_cnt++;
        total_cnt++; if (got_q.size() != NB) $display("FAIL vec_send_count: got %0d want %0d", got_q.size(), NB); else pass_cnt++;
        for (int i = 0; i < NB; i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) $display("FAIL vec_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
        end
        total_cnt++; if (addr_q.size() != NB) $display("FAIL vec_addr_count: got %0d want %0d", addr_q.size(), NB); else pass_cnt++;
        for (int i = 0; i < NB; i++) begin
            total_cnt++;
            if (addr_q[i] !== 3'(i)) $display("FAIL vec_addr%0d: got %0d want %0d", i, addr_q[i], i); else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL vec_done_count: got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL vec_busy_after: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (send_cyc_q[0] - t0 != 3) $display("FAIL vec_start_latency: got %0d want 3", send_cyc_q[0] - t0); else pass_cnt++;
        total_cnt++; if (send_cyc_q[1] - send_cyc_q[0] != 7) $display("FAIL vec_byte_spacing: got %0d want 7", send_cyc_q[1] - send_cyc_q[0]); else pass_cnt++;
    endtask

    task automatic test_scalar();
        bit to;
        int t0;
        clear_mon();
        exp_q = '{8'h44, 8'h33, 8'h22, 8'h11};
        scalar = 32'h11223344;
        @(posedge clk);
        #1 result = 2'b10;
        t0 = cyc;
        @(posedge clk);
        #1 result = 2'b00;
        // changing the source after the start edge must not affect the bytes sent
        scalar = 32'hDEADBEEF;
        wait_transfer(400, to);
        total_cnt++; if (to) $display("FAIL sc_timeout: no done within 400 cycles"); else pass_cnt++;
        total_cnt++; if (got_q.size() != SB) $display("FAIL sc_send_count: got %0d want %0d", got_q.size(), SB); else pass_cnt++;
        for (int i = 0; i < SB; i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) $display("FAIL sc_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL sc_done_count: got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (send_cyc_q[0] - t0 != 2) $display("FAIL sc_start_latency: got %0d want 2", send_cyc_q[0] - t0); else pass_cnt++;
        total_cnt++; if (send_cyc_q[1] - send_cyc_q[0] != 6) $display("FAIL sc_byte_spacing: got %0d want 6", send_cyc_q[1] - send_cyc_q[0]); else pass_cnt++;
        total_cnt++; if (addr_q.size() != 0) $display("FAIL sc_no_fetch: got %0d fetches want 0", addr_q.size()); else pass_cnt++;
    endtask

    task automatic test_held_level();
        clear_mon();
        exp_q = '{8'h88, 8'h77, 8'h66, 8'h55};
        scalar = 32'h55667788;
        @(posedge clk);
        #1 result = 2'b10;
        repeat (100) @(posedge clk);
        #1 result = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        total_cnt++; if (got_q.size() != SB) $display("FAIL hold_send_count: got %0d want %0d", got_q.size(), SB); else pass_cnt++;
        for (int i = 0; i < SB; i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) $display("FAIL hold_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
        end
        total_cnt++; if (done_cnt != 1) $display("FAIL hold_done_count: got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL hold_busy_after: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        bit to;
        int n;
        clear_mon();
        for (int i = 0; i < NB; i++) exp_q.push_back(8'hA0 + 8'(i));
        @(posedge clk);
        #1 result = 2'b11;
        @(posedge clk);
        #1 result = 2'b00;
        n = 0;
        while (got_q.size() < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        // a scalar request edge in the middle of a vector transfer
        #1 result = 2'b10;
        @(posedge clk);
        #1 result = 2'b00;
        wait_transfer(400, to);
        repeat (5) @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total_cnt++; if (to) $display("FAIL busy_timeout: no done within 400 cycles"); else pass_cnt++;
        total_cnt++; if (got_q.size() != NB) $display("FAIL busy_send_count: got %0d want %0d", got_q.size(), NB); else pass_cnt++;
        total_cnt++; if (got_q[NB-1] !== 8'hA7) $display("FAIL busy_last_byte: got %h want a7", got_q[NB-1]); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL busy_done_count: got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL busy_spurious_state: got %0d want %0d", dbg_state, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit to;
        int n;
        clear_mon();
        @(posedge clk);
        #1 result = 2'b11;
        @(posedge clk);
        #1 result = 2'b00;
        n = 0;
        while (got_q.size() < 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        total_cnt++; if (dbg_state !== ST_WAIT) $display("FAIL rst_pre_state: got %0d want %0d", dbg_state, ST_WAIT); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL rst_async_state: got %0d want %0d", dbg_state, ST_IDLE); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (tx_output !== 8'h00) $display("FAIL rst_async_tx_output: got %h want 00", tx_output); else pass_cnt++;
        total_cnt++; if (rd_addr !== 3'd0) $display("FAIL rst_async_rd_addr: got %0d want 0", rd_addr); else pass_cnt++;
        total_cnt++; if (send !== 1'b0 || done !== 1'b0) $display("FAIL rst_async_pulses: got send=%b done=%b want 0 0", send, done); else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        total_cnt++; if (got_q.size() != 4) $display("FAIL rst_late_sends: got %0d want 4", got_q.size()); else pass_cnt++;
        total_cnt++; if (done_cnt != 0) $display("FAIL rst_late_done: got %0d want 0", done_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_late_busy: got %b want 0", busy); else pass_cnt++;

        clear_mon();
        @(posedge clk);
        #1 result = 2'b11;
        @(posedge clk);
        #1 result = 2'b00;
        wait_transfer(400, to);
        total_cnt++; if (to) $display("FAIL rst_restart_timeout: no done within 400 cycles"); else pass_cnt++;
        total_cnt++; if (addr_q[0] !== 3'd0) $display("FAIL rst_restart_addr0: got %0d want 0", addr_q[0]); else pass_cnt++;
        total_cnt++; if (got_q.size() != NB) $display("FAIL rst_restart_count: got %0d want %0d", got_q.size(), NB); else pass_cnt++;
        total_cnt++; if (got_q[0] !== 8'hA0) $display("FAIL rst_restart_byte0: got %h want a0", got_q[0]); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL rst_restart_done: got %0d want 1", done_cnt); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_vector();
        test_scalar();
        test_held_level();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/result_tx_sequencer.md
# result_tx_sequencer

Upstream feeder for the UART output interface. On a result request from the accelerator core, it streams either an NBytes result vector (read from the result RAM) or a fixed-width scalar result one byte at a time. For each byte it drives the `send`/`tx_output` pair of the output interface and waits for that interface's `done` before issuing the next byte. It pulses `done` once the whole result has left the UART.

## Interface
- `NBytes`, 1024, vector length in bytes; power of two, ≥2.
- `SCALAR_BYTES`, 4, scalar result width in bytes; 1..NBytes.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `result` in 2: bit 1 = request, bit 0 = 1 vector / 0 scalar.
- `scalar` in 8*SCALAR_BYTES: scalar result; byte k = `scalar[8k+7:8k]`.
- `rd_addr` out $clog2(NBytes): result RAM read address.
- `rd_data` in 8: result RAM data; synchronous read, 1-cycle latency.
- `tx_done` in 1: one-cycle pulse from the output interface when a byte finishes.
- `send` out 1: one-cycle start pulse to the output interface.
- `tx_output` out 8: byte to transmit.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the last byte completes.

## Operation
- States:
  - IDLE: wait for a start.
  - FETCH: `rd_addr` = idx; RAM read in flight.
  - LOAD: register the byte into `tx_output`.
  - SEND: `send` = 1.
  - WAIT: hold until `tx_done`.
  - FIN: `done` = 1.
- Start condition: rising edge of `result[1]`, detected against a registered copy of `result[1]` (copy resets to 0), while in IDLE.
  - `result[0]` is sampled on the same edge and held for the whole transfer.
  - `scalar` is captured into an internal register on the same edge.
- Start transitions:
  - Vector: IDLE→FETCH, idx = 0.
  - Scalar: IDLE→LOAD, idx = 0.
- Byte load in LOAD:
  - Vector: `tx_output` ← `rd_data`.
  - Scalar: `tx_output` ← captured byte idx, least-significant byte first.
- Byte loop: LOAD→SEND→WAIT. In WAIT, on `tx_done`:
  - if idx == last (NBytes-1 for vector, SCALAR_BYTES-1 for scalar): go to FIN;
  - else idx+1, then FETCH (vector) or LOAD (scalar).
- FIN→IDLE unconditionally.
- The idx counter is $clog2(NBytes) bits wide and never wraps. The last-index compare ends the transfer before any overflow.
- Requests are ignored while busy: an edge on `result[1]` outside IDLE is dropped. A level still held high at FIN does not retrigger; a new start needs a fresh rising edge.
- `tx_done` outside WAIT is ignored.
- `tx_output` is held stable from LOAD until the next LOAD.

## Timing
- Reset values: `send` 0, `tx_output` 0x00, `rd_addr` 0, `busy` 0, `done` 0, state IDLE, idx 0.
- Reset mid-transfer: immediate return to IDLE with the values above. A byte already inside the UART may still complete. Its `tx_done` arrives in IDLE and is ignored; no done pulse follows.
- Start latency, with the start edge sampled on clock edge N:
  - Vector: FETCH at N+1, LOAD at N+2, `send` high during cycle N+3.
  - Scalar: LOAD at N+1, `send` high during cycle N+2.
- Byte-to-byte: `tx_done` sampled in WAIT at edge M → `send` for the next byte during cycle M+3 (vector) or M+2 (scalar).
- `done` pulses in the cycle after the WAIT state that saw the final `tx_done`. `busy` falls in the following cycle.
- `send` is exactly one cycle wide per byte. There is exactly one `send` per byte: NBytes per vector transfer, SCALAR_BYTES per scalar transfer.

## Structure
- Shared package `acc_pkg`:
  - state enum `tx_seq_state_t`;
  - `RES_REQ_BIT` = 1, `RES_VEC_BIT` = 0.
- No sub-module. The output interface is instantiated beside this block by the parent, not inside it.

## Test plan
- Vector, NBytes = 8, RAM[i] = 0xA0+i, `tx_done` model 5 cycles after each `send` → `send` bytes 0xA0..0xA7 in order, 8 sends, one `done`, `rd_addr` 0..7.
- Scalar, SCALAR_BYTES = 4, `scalar` = 0x11223344 → bytes 0x44, 0x33, 0x22, 0x11, then `done`. `send` is high 2 cycles after the start edge.
- `result[1]` held high for 100 cycles across a full scalar transfer → exactly one transfer and one `done`.
- Second `result[1]` pulse while busy, plus a spurious `tx_done` in IDLE → no extra sends, no extra `done`.
- `reset` asserted during WAIT of vector byte 3 → all outputs return to reset values asynchronously. A late `tx_done` produces nothing. A following request restarts from `rd_addr` 0.
- `scalar` changed during a transfer → transmitted bytes match the value captured at the start edge.
